display_scan_ctrl: RTL and testbench

Time-base and data stage that drives the two-digit seven-segment display multiplexer. It divides the system clock into a digit-scan toggle `sel` and a gated/blinking `onoff` enable, which feed the digit-enable mux directly. It also latches the two BCD values to show and decodes the currently selected one into an active-low segment pattern, so segments always match the active digit.

---
 rtl/display_scan_ctrl.sv | 112 +++++++++++
 tb/tb_display_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Display time base and segment data stage for a two-digit multiplexed
// seven-segment display. The scan toggle (sel) and visible enable (onoff) are
// registered so the digit-enable mux downstream sees glitch-free controls.
// Segments are decoded from the latched digit that sel currently selects.
module display_scan_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       blink_en,
   input  logic       load,
   input  logic [3:0] digit1_val,
   input  logic [3:0] digit4_val,
   output logic       sel,
   output logic       onoff,
   output logic [6:0] seg
);

   localparam int SW = $clog2(SCAN_DIV);
   // BLINK_DIV of 1 gives a zero-width $clog2, so keep at least one bit.
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] scan_cnt, scan_cnt_nx;
   logic [BW-1:0] blink_cnt, blink_cnt_nx;
   logic          blink_phase, blink_phase_nx;
   logic          sel_nx, onoff_nx;
   logic          scan_tick;
   logic [3:0]    d1_reg, d4_reg;
   logic [3:0]    cur_digit;

   assign scan_tick = (scan_cnt == SCAN_LAST);

   // Next-state for the scan/blink time base; disable returns everything to
   // the clean restart state so a later enable starts a full scan period.
   always_comb begin
      scan_cnt_nx    = '0;
      sel_nx         = 1'b0;
      blink_cnt_nx   = '0;
      blink_phase_nx = 1'b1;
      onoff_nx       = 1'b0;
      if (enable) begin
         scan_cnt_nx = scan_tick ? '0 : scan_cnt + 1'b1;
         sel_nx      = sel ^ scan_tick;
         if (blink_en) begin
            blink_cnt_nx   = blink_cnt;
            blink_phase_nx = blink_phase;
            if (scan_tick) begin
               if (blink_cnt == BLINK_LAST) begin
                  blink_cnt_nx   = '0;
                  blink_phase_nx = ~blink_phase;
               end else begin
                  blink_cnt_nx = blink_cnt + 1'b1;
               end
            end
         end
         onoff_nx = ~blink_en | blink_phase_nx;
      end
   end

   // Time-base and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt    <= '0;
         sel         <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
         onoff       <= 1'b0;
      end else begin
         scan_cnt    <= scan_cnt_nx;
         sel         <= sel_nx;
         blink_cnt   <= blink_cnt_nx;
         blink_phase <= blink_phase_nx;
         onoff       <= onoff_nx;
      end
   end

   // Digit latches; loads are accepted whether or not the display is enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d1_reg <= '0;
         d4_reg <= '0;
      end else if (load) begin
         d1_reg <= digit1_val;
         d4_reg <= digit4_val;
      end
   end

   assign cur_digit = sel ? d4_reg : d1_reg;

   // Active-low BCD decode (gfedcba); non-BCD codes blank the digit.
   always_comb begin
      seg = 7'h7F;
      case (cur_digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all checked against a time-count model.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

   localparam int SD = 4;
   localparam int BD = 2;

   logic       clk = 1'b0;
   logic       reset, enable, blink_en, load;
   logic [3:0] d1v, d4v;
   logic       sel, onoff;
   logic [6:0] seg;

   int checks = 0;
   int errors = 0;

   display_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk(clk), .reset(reset), .enable(enable), .blink_en(blink_en),
      .load(load), .digit1_val(d1v), .digit4_val(d4v),
      .sel(sel), .onoff(onoff), .seg(seg)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                  7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h7F,
                                  7'h7F, 7'h7F, 7'h7F, 7'h7F};

   // Model: m_n = enabled edges since last clear, m_k = scan ticks seen
   // during the current blink_en run.
   int         m_n = 0;
   int         m_k = 0;
   logic       m_on = 1'b0;
   logic [3:0] m_d1 = 4'd0;
   logic [3:0] m_d4 = 4'd0;

   function automatic int k_next(input int n, input int k, input logic b);
      if (!b) return 0;
      if (((n + 1) % SD) == 0) return k + 1;
      return k;
   endfunction

   function automatic logic exp_sel();
      return ((m_n / SD) % 2) == 1;
   endfunction

   function automatic logic [6:0] exp_seg();
      return exp_sel() ? seg_tab[m_d4] : seg_tab[m_d1];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_n  <= 0;
         m_k  <= 0;
         m_on <= 1'b0;
         m_d1 <= 4'd0;
         m_d4 <= 4'd0;
      end else begin
         if (!enable) begin
            m_n  <= 0;
            m_k  <= 0;
            m_on <= 1'b0;
         end else begin
            m_n  <= m_n + 1;
            m_k  <= k_next(m_n, m_k, blink_en);
            m_on <= !blink_en || (((k_next(m_n, m_k, blink_en) / BD) % 2) == 0);
         end
         if (load) begin
            m_d1 <= d1v;
            m_d4 <= d4v;
         end
      end
   end

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model comparison every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("model_sel", 7'(sel), 7'(exp_sel()));
      chk("model_onoff", 7'(onoff), 7'(m_on));
      chk("model_seg", seg, exp_seg());
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      reset = 1'b1; enable = 1'b1; blink_en = 1'b0; load = 1'b0;
      d1v = 4'd0; d4v = 4'd0;
      #3;
      chk("rst_sel", 7'(sel), 7'h0);
      chk("rst_onoff", 7'(onoff), 7'h0);
      chk("rst_seg", seg, 7'h40);
      step(); step();
      reset = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (e == 1)  chk("s1_onoff_e1", 7'(onoff), 7'h1);
         if (e == 3)  chk("s1_sel_e3", 7'(sel), 7'h0);
         if (e == 4)  chk("s1_sel_e4", 7'(sel), 7'h1);
         if (e == 7)  chk("s1_sel_e7", 7'(sel), 7'h1);
         if (e == 8)  chk("s1_sel_e8", 7'(sel), 7'h0);
         if (e == 11) chk("s1_sel_e11", 7'(sel), 7'h0);
         if (e == 12) chk("s1_sel_e12", 7'(sel), 7'h1);
      end
      load = 1'b1; d1v = 4'd8; d4v = 4'd8;
      step();
      load = 1'b0;
      chk("pre_rst_seg", seg, 7'h00);
      #2 reset = 1'b1;
      #1;
      chk("async_sel", 7'(sel), 7'h0);
      chk("async_onoff", 7'(onoff), 7'h0);
      chk("async_seg", seg, 7'h40);
      step();
      reset = 1'b0;

      enable = 1'b0;
      step();
      enable = 1'b1; load = 1'b1; d1v = 4'd3; d4v = 4'd7;
      step();
      load = 1'b0;
      chk("s2_seg_d1", seg, 7'h30);
      chk("s2_sel", 7'(sel), 7'h0);
      chk("s2_onoff", 7'(onoff), 7'h1);
      step(); step();
      chk("s2_seg_e3", seg, 7'h30);
      step();
      chk("s2_sel_e4", 7'(sel), 7'h1);
      chk("s2_seg_d4", seg, 7'h78);
      chk("s2_onoff_e4", 7'(onoff), 7'h1);

      blink_en = 1'b1;
      for (int j = 1; j <= 25; j++) begin
         step();
         if (j == 7)  chk("s3_lit_j7", 7'(onoff), 7'h1);
         if (j == 8)  chk("s3_dark_j8", 7'(onoff), 7'h0);
         if (j == 15) chk("s3_dark_j15", 7'(onoff), 7'h0);
         if (j == 16) chk("s3_lit_j16", 7'(onoff), 7'h1);
         if (j == 24) chk("s3_dark_j24", 7'(onoff), 7'h0);
      end
      blink_en = 1'b0;
      step();
      chk("s3_unblink", 7'(onoff), 7'h1);

      load = 1'b1; d1v = 4'd12; d4v = 4'd9;
      step();
      load = 1'b0;
      for (int j = 0; j < 8; j++) begin
         chk("s4_seg", seg, sel ? 7'h10 : 7'h7F);
         step();
      end

      w = 0;
      while (sel !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      chk("s5_wait_sel", 7'(sel), 7'h1);
      step();
      enable = 1'b0;
      step();
      chk("s5_dis_sel", 7'(sel), 7'h0);
      chk("s5_dis_onoff", 7'(onoff), 7'h0);
      load = 1'b1; d1v = 4'd5; d4v = 4'd5;
      step();
      load = 1'b0;
      step();
      chk("s5_frozen_sel", 7'(sel), 7'h0);
      enable = 1'b1;
      step();
      chk("s5_seg", seg, 7'h12);
      chk("s5_onoff", 7'(onoff), 7'h1);
      step(); step();
      chk("s5_sel_e3", 7'(sel), 7'h0);
      step();
      chk("s5_sel_e4", 7'(sel), 7'h1);

      for (int j = 0; j < 7; j++) step();
      chk("s6_pre_sel", 7'(sel), 7'h0);
      load = 1'b1; d1v = 4'd1; d4v = 4'd8;
      step();
      load = 1'b0;
      chk("s6_sel", 7'(sel), 7'h1);
      chk("s6_seg", seg, 7'h00);

      for (int i = 0; i < 4000; i++) begin
         enable = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
         load = ($urandom_range(0, 15) == 0);
         d1v = 4'($urandom_range(0, 15));
         d4v = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b1;
            #1;
            chk("rand_async_sel", 7'(sel), 7'h0);
            chk("rand_async_onoff", 7'(onoff), 7'h0);
            chk("rand_async_seg", seg, 7'h40);
            step();
            reset = 1'b0;
         end else begin
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
